// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, controller numbers and the parser /
// running-status types used by midi_note_tracker and midi_note_stack.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] CC       = 4'hB;

    localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

    typedef enum logic [1:0] {
        IDLE,
        DATA1,
        DATA2
    } parser_state_t;

    // RS_IGNORE marks a channel message we do not track; its data bytes are dropped.
    typedef enum logic [2:0] {
        RS_NONE,
        RS_IGNORE,
        RS_NOTE_OFF,
        RS_NOTE_ON,
        RS_CC
    } run_status_t;

    typedef struct packed {
        logic [6:0] note;
        logic [6:0] vel;
    } note_entry_t;

    function automatic run_status_t decode_status(input logic [7:0] status,
                                                  input logic [3:0] channel);
        run_status_t rs;
        rs = RS_IGNORE;
        if (status[3:0] == channel) begin
            case (status[7:4])
                NOTE_OFF: rs = RS_NOTE_OFF;
                NOTE_ON:  rs = RS_NOTE_ON;
                CC:       rs = RS_CC;
                default:  rs = RS_IGNORE;
            endcase
        end
        return rs;
    endfunction

    function automatic logic tracks_messages(input run_status_t rs);
        return rs inside {RS_NOTE_OFF, RS_NOTE_ON, RS_CC};
    endfunction

endpackage

// File: rtl/midi_note_stack.sv
// Held-note LIFO: push moves a note to the top (dropping the oldest entry when
// full), remove deletes a note wherever it sits, clear empties the stack.
module midi_note_stack
    import midi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       push,
    input  logic       remove,
    input  logic [6:0] note,
    input  logic [6:0] vel,
    output logic [6:0] top_note,
    output logic [6:0] next_note,
    output logic [6:0] next_vel,
    output logic       next_valid,
    output logic       empty,
    output logic       full
);

    localparam int            CW        = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    note_entry_t   mem_q    [DEPTH];
    note_entry_t   mem_d    [DEPTH];
    note_entry_t   after_rm [DEPTH];
    logic [CW-1:0] count_q, count_d, count_rm;
    logic          hit;
    int            hit_idx;

    // NOTE: every variable gets a default at the top of the block, so no path
    // can leave one unassigned and infer a latch.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && CW'(i) < count_q && mem_q[i].note == note) begin
                hit     = 1'b1;
                hit_idx = i;
            end
        end

        // Entries below a removed one move up by a slot; index 0 is the top.
        for (int i = 0; i < DEPTH - 1; i++) begin
            after_rm[i] = (hit && i >= hit_idx) ? mem_q[i + 1] : mem_q[i];
        end
        after_rm[DEPTH-1] = mem_q[DEPTH-1];
        count_rm          = count_q - CW'(hit);

        mem_d   = mem_q;
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (push) begin
            mem_d[0] = '{note: note, vel: vel};
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = after_rm[i - 1];
            end
            count_d = (count_rm == DEPTH_CNT) ? DEPTH_CNT : count_rm + CW'(1);
        end else if (remove) begin
            mem_d   = after_rm;
            count_d = count_rm;
        end
    end

    // NOTE: only the occupancy count is reset; slots at or beyond it are never
    // read, so the storage array is plain clocked flops without a reset network.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign top_note   = mem_q[0].note;
    assign next_note  = mem_q[1].note;
    assign next_vel   = mem_q[1].vel;
    assign next_valid = count_q > CW'(1);
    assign empty      = count_q == '0;
    assign full       = count_q == DEPTH_CNT;

endmodule

// File: rtl/midi_note_tracker.sv
// MIDI note tracker: parses one channel's byte stream and drives the sounding
// note. Define NOTE_STACK_EN to recall earlier held notes on release.
module midi_note_tracker
    import midi_pkg::*;
#(
    parameter logic [3:0] CHANNEL     = 4'd0,
    parameter int         STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       midi_valid,
    input  logic [7:0] midi_byte,
    output logic       note_on,
    output logic       note_repeat,
    output logic [6:0] note_start,
    output logic [6:0] vel_start
);

    parser_state_t state_q, state_d;
    run_status_t   rs_q, rs_d;
    logic [6:0]    data1_q, data1_d;
    logic          msg_done;

    // Real-time bytes (0xF8-0xFF) may arrive anywhere and are invisible here.
    always_comb begin
        state_d  = state_q;
        rs_d     = rs_q;
        data1_d  = data1_q;
        msg_done = 1'b0;
        if (midi_valid && midi_byte < 8'hF8) begin
            if (midi_byte >= 8'hF0) begin
                rs_d    = RS_NONE;
                state_d = IDLE;
            end else if (midi_byte[7]) begin
                rs_d    = decode_status(midi_byte, CHANNEL);
                state_d = tracks_messages(rs_d) ? DATA1 : IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (tracks_messages(rs_q)) begin
                            data1_d = midi_byte[6:0];
                            state_d = DATA2;
                        end
                    end
                    DATA1: begin
                        data1_d = midi_byte[6:0];
                        state_d = DATA2;
                    end
                    DATA2: begin
                        msg_done = 1'b1;
                        state_d  = tracks_messages(rs_q) ? DATA1 : IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    logic [6:0] data2;
    logic       is_note_on, is_note_off, is_all_off, sounding_hit;

    assign data2       = midi_byte[6:0];
    assign is_note_on  = msg_done && rs_q == RS_NOTE_ON && data2 != '0;
    assign is_note_off = msg_done && (rs_q == RS_NOTE_OFF || (rs_q == RS_NOTE_ON && data2 == '0));
    assign is_all_off  = msg_done && rs_q == RS_CC &&
                         (data1_q == CC_ALL_SOUND_OFF || data1_q == CC_ALL_NOTES_OFF);

`ifdef NOTE_STACK_EN
    logic [6:0] top_note, next_note, next_vel;
    logic       next_valid, stack_empty, stack_full_unused;

    midi_note_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (is_all_off),
        .push       (is_note_on),
        .remove     (is_note_off),
        .note       (data1_q),
        .vel        (data2),
        .top_note   (top_note),
        .next_note  (next_note),
        .next_vel   (next_vel),
        .next_valid (next_valid),
        .empty      (stack_empty),
        .full       (stack_full_unused)
    );

    // The sounding note is always the stack top while anything is held.
    assign sounding_hit = !stack_empty && top_note == data1_q;
`else
    localparam int STACK_DEPTH_UNUSED = STACK_DEPTH;

    assign sounding_hit = note_on && note_start == data1_q;
`endif

    logic       note_on_d, note_repeat_d;
    logic [6:0] note_start_d, vel_start_d;

    always_comb begin
        note_on_d     = note_on;
        note_repeat_d = 1'b0;
        note_start_d  = note_start;
        vel_start_d   = vel_start;
        if (is_note_on) begin
            note_on_d     = 1'b1;
            note_repeat_d = sounding_hit;
            note_start_d  = data1_q;
            vel_start_d   = data2;
        end else if (is_note_off && sounding_hit) begin
`ifdef NOTE_STACK_EN
            if (next_valid) begin
                note_start_d = next_note;
                vel_start_d  = next_vel;
            end else begin
                note_on_d = 1'b0;
            end
`else
            note_on_d = 1'b0;
`endif
        end else if (is_all_off) begin
            note_on_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rs_q        <= RS_NONE;
            data1_q     <= '0;
            note_on     <= 1'b0;
            note_repeat <= 1'b0;
            note_start  <= '0;
            vel_start   <= '0;
        end else begin
            state_q     <= state_d;
            rs_q        <= rs_d;
            data1_q     <= data1_d;
            note_on     <= note_on_d;
            note_repeat <= note_repeat_d;
            note_start  <= note_start_d;
            vel_start   <= vel_start_d;
        end
    end

endmodule

// File: doc/midi_note_tracker.md
MIDI_NOTE_TRACKER -- requirements
Module: midi_note_tracker

Interface
REQ-001 SHALL have parameter CHANNEL, default 4'd0: MIDI channel (0-15) this instance responds to.
REQ-002 SHALL have parameter STACK_DEPTH, default 4: held-note stack entries (2-8).
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 midi_valid  input  1  one-cycle strobe; midi_byte is valid this cycle.
REQ-006 midi_byte  input  8  received MIDI byte.
REQ-007 note_on  output  1  level; high while a note is sounding.
REQ-008 note_repeat  output  1  one-cycle pulse on retrigger of the sounding note.
REQ-009 note_start  output  7  currently sounding note number.
REQ-010 vel_start  output  7  velocity of the currently sounding note.

Function
REQ-011 Parser SHALL use states IDLE, DATA1, DATA2; bytes processed only when midi_valid=1.
REQ-012 Byte 0xF8-0xFF SHALL be ignored, leaving state and running status unchanged.
REQ-013 Byte 0xF0-0xF7 SHALL clear running status and go to IDLE; data bytes in IDLE are discarded.
REQ-014 Status 0x80/0x90/0xB0 with low nibble == CHANNEL SHALL latch running status and go to DATA1; any other channel status latches "ignore" running status.
REQ-015 Data byte in IDLE with a valid latched running status SHALL be treated as DATA1 (running status).
REQ-016 DATA1 SHALL store the data byte and go to DATA2; DATA2 SHALL complete the message and return to DATA1 if running status is held, else IDLE.
REQ-017 A status byte (0x80-0xEF) received in DATA1 or DATA2 SHALL abort the partial message and be handled per REQ-014.
REQ-018 Note On with velocity 0 SHALL be handled as Note Off.
REQ-019 Outputs SHALL update on the clock edge after the cycle accepting the completing data byte (1-cycle latency).
REQ-020 Note On, no note sounding: note_start/vel_start load, note_on=1, note_repeat stays 0.
REQ-021 Note On, different note sounding: note_start/vel_start load, note_on stays 1, note_repeat stays 0 (the envelope detects the change).
REQ-022 Note On, same note sounding: vel_start loads, note_repeat pulses 1 for exactly one cycle, note_on stays 1.
REQ-023 Note Off for the sounding note: handled per Configuration.
REQ-024 Note Off for a non-sounding note: no output change; entry removed from stack if present.
REQ-025 CC 123 (All Notes Off) or CC 120: stack cleared, note_on=0; note_start/vel_start hold.
REQ-026 Note Off release velocity and other CC numbers SHALL be ignored.

Reset
REQ-027 reset_n=0 SHALL immediately force: parser IDLE, running status none, stack empty, note_on=0, note_repeat=0, note_start=0, vel_start=0.
REQ-028 Reset mid-message SHALL discard the partial message; first byte after release is parsed from IDLE.

Configuration
REQ-029 With macro NOTE_STACK_EN defined, each Note On SHALL push (note, velocity) onto a STACK_DEPTH LIFO, first removing any existing entry with the same note.
REQ-030 With NOTE_STACK_EN, a push when full SHALL drop the oldest entry.
REQ-031 With NOTE_STACK_EN, Note Off of the top entry SHALL pop it; if non-empty, note_start/vel_start load the new top with note_on held 1; if empty, note_on=0.
REQ-032 Without NOTE_STACK_EN, no stack SHALL exist; Note Off of the sounding note sets note_on=0.

Structure
REQ-033 Shared package midi_pkg SHALL hold status nibble constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, CC=4'hB), CC numbers 120/123, and the parser state typedef.
REQ-034 The stack SHALL be a sub-module midi_note_stack (push, remove-by-note, top, empty, full).

Verification
REQ-035 90 3C 64 (CHANNEL=0) -> next cycle note_on=1, note_start=60, vel_start=100, note_repeat=0.
REQ-036 90 3C 64, then 3C 50 via running status -> one-cycle note_repeat pulse, vel_start=80, note_on remains 1.
REQ-037 90 3C 64, F8 injected between 3C and 64 -> result identical to REQ-035.
REQ-038 NOTE_STACK_EN: 90 3C 64, 90 40 50, 80 40 00 -> note_start=60, vel_start=100, note_on stays 1; then 90 3C 00 -> note_on=0.
REQ-039 91 3C 64 (CHANNEL=0) -> no output change; then B0 7B 00 after a held note -> note_on=0.
REQ-040 reset_n low after 90 3C only, then release and 3C 64 -> outputs stay at reset values.
